maxpool_writer: RTL and testbench

MAXPOOL_WRITER -- requirements
Module: maxpool_writer

---
 rtl/maxpool_pkg.sv | 17 +
 rtl/maxpool_writer_fp16_max.sv | 21 ++
 rtl/maxpool_writer.sv | 206 ++++++++++++++++++++
 tb/tb_maxpool_writer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types for the 2x2 max-pool output writer.
// Optional feature: MAXPOOL_RELU_EN clamps negative inputs to +0 before pooling.
package maxpool_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVEN_ROW,
        S_ODD_ROW,
        S_FLUSH,
        S_DONE
    } state_e;

endpackage

// File: rtl/maxpool_writer_fp16_max.sv
// Combinational fp16 max in sign-magnitude order.
// +0/-0 compare equal and the first operand wins; NaN/Inf are ordered by raw bits.
module fp16_max
    import maxpool_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t y
);

    logic signed [16:0] key_a;
    logic signed [16:0] key_b;

    // Map sign-magnitude onto a signed key so ties (incl. +0/-0) keep operand a
    always_comb begin
        key_a = a[15] ? -$signed({2'b00, a[14:0]}) : $signed({2'b00, a[14:0]});
        key_b = b[15] ? -$signed({2'b00, b[14:0]}) : $signed({2'b00, b[14:0]});
        y     = (key_b > key_a) ? b : a;
    end

endmodule

// File: rtl/maxpool_writer.sv
// 2x2 max-pool of a raster fp16 stream, packing pooled pairs into 32-bit SRAM words.
// Optional feature: MAXPOOL_RELU_EN replaces negative din by +0 before pooling.
module maxpool_writer
    import maxpool_pkg::*;
#(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 16,
    parameter int OUT_BASE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int          CW   = $clog2(IMG_W);
    localparam int          RW   = $clog2(IMG_H);
    localparam int          LB   = IMG_W / 2;
    localparam int          BW   = (LB > 1) ? $clog2(LB) : 1;
    localparam logic [12:0] BASE = 13'(OUT_BASE);

    state_e         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    fp16_t          prev_q, prev_d;
    fp16_t          pooled_q, pooled_d;
    logic           pooled_vld_q, pooled_vld_d;
    fp16_t          lo_q, lo_d;
    logic           half_q, half_d;
    logic           wr_en_q, wr_en_d;
    logic [12:0]    wr_addr_q, wr_addr_d;
    logic [31:0]    wr_data_q, wr_data_d;
    logic           busy_q, busy_d;
    logic           frame_done_q, frame_done_d;
    fp16_t          lbuf_q [LB];
    fp16_t          lbuf_d [LB];

    fp16_t          pix;
    fp16_t          pair;
    fp16_t          pool;
    fp16_t          lbuf_rd;
    logic [BW-1:0]  idx;
    logic           accept;
    logic           row_end;

    // Input conditioning: optional ReLU clamp ahead of all comparisons
    always_comb begin
`ifdef MAXPOOL_RELU_EN
        pix = din[15] ? FP16_ZERO : din;
`else
        pix = din;
`endif
        idx     = BW'(col_q >> 1);
        lbuf_rd = lbuf_q[idx];
    end

    // Horizontal pair max, then vertical max against the buffered even row
    fp16_max u_pair (.a(prev_q),  .b(pix),  .y(pair));
    fp16_max u_pool (.a(lbuf_rd), .b(pair), .y(pool));

    // Next-state: row walker, pooling pipe, word packer and frame control
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        prev_d       = prev_q;
        pooled_d     = pooled_q;
        pooled_vld_d = 1'b0;
        lo_d         = lo_q;
        half_d       = half_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        lbuf_d       = lbuf_q;

        accept  = din_valid && !frame_start &&
                  (state_q == S_EVEN_ROW || state_q == S_ODD_ROW);
        row_end = accept && (col_q == CW'(IMG_W - 1));

        if (accept) begin
            if (!col_q[0]) begin
                prev_d = pix;
            end else if (state_q == S_EVEN_ROW) begin
                lbuf_d[idx] = pair;
            end else begin
                pooled_d     = pool;
                pooled_vld_d = 1'b1;
            end
            col_d = row_end ? '0 : col_q + CW'(1);
            if (row_end) begin
                if (state_q == S_EVEN_ROW) begin
                    state_d = S_ODD_ROW;
                end else if (row_q == RW'(IMG_H - 1)) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_EVEN_ROW;
                end
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end
        end

        // Pack pooled values low half first; write the word once both halves exist
        if (pooled_vld_q) begin
            if (half_q) begin
                wr_data_d = {pooled_q, lo_q};
                wr_en_d   = 1'b1;
                half_d    = 1'b0;
            end else begin
                lo_d   = pooled_q;
                half_d = 1'b1;
            end
        end

        if (wr_en_q) begin
            wr_addr_d = wr_addr_q + 13'd1;
        end

        unique case (state_q)
            S_FLUSH: begin
                // The frame's last pooled value lands here; pad any unpaired half
                if (pooled_vld_q && !half_q) begin
                    wr_data_d = {FP16_ZERO, pooled_q};
                    wr_en_d   = 1'b1;
                    half_d    = 1'b0;
                end else if (!pooled_vld_q && half_q) begin
                    wr_data_d = {FP16_ZERO, lo_q};
                    wr_en_d   = 1'b1;
                    half_d    = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: ;
        endcase

        // Arming (or re-arming mid-frame) discards everything in flight
        if (frame_start) begin
            state_d      = S_EVEN_ROW;
            col_d        = '0;
            row_d        = '0;
            pooled_vld_d = 1'b0;
            half_d       = 1'b0;
            wr_en_d      = 1'b0;
            wr_addr_d    = BASE;
            busy_d       = 1'b1;
            frame_done_d = 1'b0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            prev_q       <= FP16_ZERO;
            pooled_q     <= FP16_ZERO;
            pooled_vld_q <= 1'b0;
            lo_q         <= FP16_ZERO;
            half_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            prev_q       <= prev_d;
            pooled_q     <= pooled_d;
            pooled_vld_q <= pooled_vld_d;
            lo_q         <= lo_d;
            half_q       <= half_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer: no reset, every entry is written in an even row before use
    always_ff @(posedge clk) begin
        lbuf_q <= lbuf_d;
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_writer.sv
// Self-checking bench: four maxpool_writer geometries driven with random frames
// and compared against a plain-arithmetic 2x2 pooling/packing model.
module tb_maxpool_writer;

    logic        clk;
    logic        rst;
    logic        fs  [4];
    logic        dv  [4];
    logic [15:0] din [4];
    logic        wr_en [4];
    logic [12:0] wr_addr [4];
    logic [31:0] wr_data [4];
    logic        busy [4];
    logic        frame_done [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [1:0]  s;
        logic [12:0] a;
        logic [31:0] d;
        logic [31:0] c;
    } wr_t;

    wr_t         wq[$];
    int          done_cnt  [4];
    int          done_cyc  [4];
    logic        done_busy [4];
    logic [15:0] pix [512];

    maxpool_writer #(.IMG_W(32), .IMG_H(16), .OUT_BASE(0)) u0 (
        .clk(clk), .rst(rst), .frame_start(fs[0]), .din(din[0]), .din_valid(dv[0]),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .busy(busy[0]), .frame_done(frame_done[0]));
    maxpool_writer #(.IMG_W(6), .IMG_H(2), .OUT_BASE(8191)) u1 (
        .clk(clk), .rst(rst), .frame_start(fs[1]), .din(din[1]), .din_valid(dv[1]),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .busy(busy[1]), .frame_done(frame_done[1]));
    maxpool_writer #(.IMG_W(4), .IMG_H(2), .OUT_BASE(5)) u2 (
        .clk(clk), .rst(rst), .frame_start(fs[2]), .din(din[2]), .din_valid(dv[2]),
        .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
        .busy(busy[2]), .frame_done(frame_done[2]));
    maxpool_writer #(.IMG_W(2), .IMG_H(2), .OUT_BASE(0)) u3 (
        .clk(clk), .rst(rst), .frame_start(fs[3]), .din(din[3]), .din_valid(dv[3]),
        .wr_en(wr_en[3]), .wr_addr(wr_addr[3]), .wr_data(wr_data[3]),
        .busy(busy[3]), .frame_done(frame_done[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collect writes and frame_done pulses away from the active edge
    always @(negedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (wr_en[s]) wq.push_back('{2'(s), wr_addr[s], wr_data[s], 32'(cyc)});
            if (frame_done[s]) begin
                done_cnt[s]  = done_cnt[s] + 1;
                done_cyc[s]  = cyc;
                done_busy[s] = busy[s];
            end
        end
    end

    function automatic int geo_w(input int s);
        case (s) 0: return 32; 1: return 6; 2: return 4; default: return 2; endcase
    endfunction
    function automatic int geo_h(input int s);
        return (s == 0) ? 16 : 2;
    endfunction
    function automatic int geo_base(input int s);
        case (s) 1: return 8191; 2: return 5; default: return 0; endcase
    endfunction

    // Reference ordering: a signed integer from sign and magnitude
    function automatic int fp_ord(input logic [15:0] v);
        int m;
        m = int'(v[14:0]);
        return v[15] ? -m : m;
    endfunction
    function automatic logic [15:0] fp_max(input logic [15:0] a, input logic [15:0] b);
        return (fp_ord(b) > fp_ord(a)) ? b : a;
    endfunction
    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef MAXPOOL_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] rnd_fp();
        case ($urandom_range(7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7C00;
            3: return 16'hFC00;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic f, input logic v, input logic [15:0] d);
        fs[s]  = f;
        dv[s]  = v;
        din[s] = d;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pix[i] = rnd_fp();
    endtask

    // Drive one frame (optionally preceded by an aborted partial frame) and check it
    task automatic run_frame(input int s, input int n_pre, input int gap_pct);
        int w, h, n, last, k;
        logic [15:0] pv[$];
        logic [15:0] e, o, lo, hi;
        logic [12:0] ea;
        logic [31:0] ed;
        w = geo_w(s); h = geo_h(s); n = w * h;
        if (n_pre > 0) begin
            drive(s, 1'b1, 1'b0, 16'h0);
            tick();
            for (int i = 0; i < n_pre; i++) begin
                drive(s, 1'b0, 1'b1, rnd_fp());
                tick();
            end
        end
        // frame_start coincident with a valid sample: that sample must be dropped
        drive(s, 1'b1, 1'b1, rnd_fp());
        wq.delete();
        done_cnt[s] = 0;
        tick();
        total++;
        if (busy[s] !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_arm s=%0d got=%b exp=1", s, busy[s]);
        end
        last = cyc;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                drive(s, 1'b0, 1'b0, rnd_fp());
                tick();
            end
            drive(s, 1'b0, 1'b1, pix[i]);
            last = cyc;
            tick();
        end
        // Keep din_valid high through FLUSH/DONE/IDLE: it must be ignored
        k = 0;
        while (k < 40 && done_cnt[s] == 0) begin
            drive(s, 1'b0, 1'b1, rnd_fp());
            tick();
            k++;
        end
        repeat (4) begin
            drive(s, 1'b0, 1'b1, rnd_fp());
            tick();
        end
        drive(s, 1'b0, 1'b0, 16'h0);

        for (int r = 0; r < h / 2; r++)
            for (int c = 0; c < w / 2; c++) begin
                e = fp_max(relu(pix[2*r*w + 2*c]), relu(pix[2*r*w + 2*c + 1]));
                o = fp_max(relu(pix[(2*r+1)*w + 2*c]), relu(pix[(2*r+1)*w + 2*c + 1]));
                pv.push_back(fp_max(e, o));
            end

        total++;
        if (wq.size() != (pv.size() + 1) / 2) begin
            bad++;
            $display("FAIL write_count s=%0d got=%0d exp=%0d", s, wq.size(), (pv.size() + 1) / 2);
        end
        for (int i = 0; i < wq.size() && 2 * i < pv.size(); i++) begin
            lo = pv[2*i];
            hi = (2*i + 1 < pv.size()) ? pv[2*i+1] : 16'h0000;
            ed = {hi, lo};
            ea = 13'(geo_base(s) + i);
            total++;
            if (wq[i].s !== 2'(s) || wq[i].a !== ea || wq[i].d !== ed) begin
                bad++;
                $display("FAIL write_%0d s=%0d got=dut%0d@%h:%h exp=dut%0d@%h:%h",
                         i, s, wq[i].s, wq[i].a, wq[i].d, s, ea, ed);
            end
        end
        if (wq.size() > 0) begin
            total++;
            if (wq[wq.size()-1].c != 32'(last + 2)) begin
                bad++;
                $display("FAIL latency s=%0d got=%0d exp=%0d", s, wq[wq.size()-1].c, last + 2);
            end
            total++;
            if (done_cnt[s] != 1 || done_cyc[s] != int'(wq[wq.size()-1].c) + 1) begin
                bad++;
                $display("FAIL frame_done s=%0d got=cnt%0d@%0d exp=cnt1@%0d",
                         s, done_cnt[s], done_cyc[s], wq[wq.size()-1].c + 1);
            end
        end
        total++;
        if (done_busy[s] !== 1'b0 || busy[s] !== 1'b0) begin
            bad++;
            $display("FAIL busy_at_done s=%0d got=%b/%b exp=0/0", s, done_busy[s], busy[s]);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) begin
            total++;
            if (wr_en[s] !== 1'b0 || busy[s] !== 1'b0 || frame_done[s] !== 1'b0 ||
                wr_data[s] !== 32'h0 || wr_addr[s] !== 13'(geo_base(s))) begin
                bad++;
                $display("FAIL reset_state s=%0d got=%b%b%b %h %h exp=000 00000000 %h", s,
                         wr_en[s], busy[s], frame_done[s], wr_data[s], wr_addr[s],
                         13'(geo_base(s)));
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] exp36;
        pix[0] = 16'h3C00; pix[1] = 16'h4000; pix[2] = 16'h4200; pix[3] = 16'h4400;
        pix[4] = 16'h4500; pix[5] = 16'h4600; pix[6] = 16'h4700; pix[7] = 16'h4800;
        run_frame(2, 0, 0);
        total++;
        if (wq.size() < 1 || wq[0].d !== 32'h4800_4600 || wq[0].a !== 13'd5) begin
            bad++;
            $display("FAIL vec_4x2 got=%h@%h exp=48004600@0005",
                     (wq.size() > 0) ? wq[0].d : 32'hx, (wq.size() > 0) ? wq[0].a : 13'hx);
        end
        pix[0] = 16'hC200; pix[1] = 16'hBC00; pix[2] = 16'hC000; pix[3] = 16'hC400;
`ifdef MAXPOOL_RELU_EN
        exp36 = 32'h0000_0000;
`else
        exp36 = 32'h0000_BC00;
`endif
        run_frame(3, 0, 0);
        total++;
        if (wq.size() < 1 || wq[0].d !== exp36) begin
            bad++;
            $display("FAIL vec_2x2_neg got=%h exp=%h", (wq.size() > 0) ? wq[0].d : 32'hx, exp36);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 512; i++) pix[i] = 16'(i);
        run_frame(0, 0, 0);
    endtask

    task automatic test_random();
        fill_random(512); run_frame(0, 0, 30);
        for (int r = 0; r < 3; r++) begin
            fill_random(12); run_frame(1, 0, 25);
            fill_random(8);  run_frame(2, 0, 25);
            fill_random(4);  run_frame(3, 0, 25);
        end
    endtask

    task automatic test_back_to_back();
        fill_random(12); run_frame(1, 0, 0);
        fill_random(12); run_frame(1, 0, 0);
    endtask

    task automatic test_abort();
        fill_random(512);
        run_frame(0, 40, 10);
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b1, 1'b0, 16'h0);
        tick();
        for (int i = 0; i < 100; i++) begin
            drive(0, 1'b0, 1'b1, rnd_fp());
            tick();
        end
        rst = 1'b1;
        #2;
        total++;
        if (wr_en[0] !== 1'b0 || busy[0] !== 1'b0 || wr_addr[0] !== 13'd0 ||
            wr_data[0] !== 32'h0 || frame_done[0] !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got=%b%b %h %h %b exp=00 0000 00000000 0",
                     wr_en[0], busy[0], wr_addr[0], wr_data[0], frame_done[0]);
        end
        #1;
        rst = 1'b0;
        wq.delete();
        done_cnt[0] = 0;
        for (int i = 0; i < 600; i++) begin
            drive(0, 1'b0, 1'b1, rnd_fp());
            tick();
        end
        drive(0, 1'b0, 1'b0, 16'h0);
        tick();
        total++;
        if (wq.size() != 0 || done_cnt[0] != 0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle got=writes%0d done%0d busy%b exp=writes0 done0 busy0",
                     wq.size(), done_cnt[0], busy[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            fs[s] = 1'b0; dv[s] = 1'b0; din[s] = 16'h0;
            done_cnt[s] = 0; done_cyc[s] = 0; done_busy[s] = 1'b0;
        end
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_directed();
        test_ramp();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
